// File: rtl/remote_load_latency_stats_pkg.sv
// Shared definitions for the remote-load latency statistics block:
// event type encoding, query field selects and the per-type statistics record.
package remote_load_latency_stats_pkg;

  typedef enum logic [1:0] {
    e_rl_stat_int    = 2'd0,
    e_rl_stat_float  = 2'd1,
    e_rl_stat_icache = 2'd2,
    e_rl_stat_rsvd   = 2'd3
  } rl_stat_type_e;

  // rd_sel_i encodings; bin k is read at rl_sel_bin0 + k
  localparam logic [4:0] rl_sel_count = 5'd0;
  localparam logic [4:0] rl_sel_sum   = 5'd1;
  localparam logic [4:0] rl_sel_max   = 5'd2;
  localparam logic [4:0] rl_sel_min   = 5'd3;
  localparam logic [4:0] rl_sel_bin0  = 5'd4;

  localparam int rl_stat_num_types = 3;
  localparam int rl_stat_field_w   = 64;

  // Scalar statistics of one type, zero-extended to a common width for readout
  typedef struct packed {
    logic [rl_stat_field_w-1:0] count;
    logic [rl_stat_field_w-1:0] sum;
    logic [rl_stat_field_w-1:0] lat_max;
    logic [rl_stat_field_w-1:0] lat_min;
  } rl_stat_s;

endpackage

// File: rtl/remote_load_latency_stats_bin_index.sv
// Log2 histogram bin selection: index of the highest set bit, with latencies
// below 2 in bin 0 and everything at or above 2^(num_bins_p-1) clamped to the top bin.
module rl_latency_bin_index #(
  parameter int num_bins_p      = 8,
  parameter int latency_width_p = 32,
  parameter int bin_w_p         = $clog2(num_bins_p)
) (
  input  logic [latency_width_p-1:0] i_latency,
  output logic [bin_w_p-1:0]         o_bin
);

  logic w_clamp;

  assign w_clamp = |i_latency[latency_width_p-1:num_bins_p-1];

  always_comb begin
    o_bin = '0;
    // ascending scan so the highest set bit wins; bit 0 maps to bin 0 as well
    for (int k = 0; k < num_bins_p - 1; k++) begin
      if (i_latency[k]) o_bin = bin_w_p'(k);
    end
    if (w_clamp) o_bin = bin_w_p'(num_bins_p - 1);
  end

endmodule

// File: rtl/remote_load_latency_stats.sv
// Per-type remote load latency statistics: count, sum, max, min and a log2
// histogram, fed through a one-entry stage register and read by a registered query port.
module remote_load_latency_stats
  import remote_load_latency_stats_pkg::*;
#(
  parameter int num_bins_p      = 8,
  parameter int latency_width_p = 32,
  parameter int count_width_p   = 32,
  parameter int sum_width_p     = 48
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [1:0]                 type_i,
  input  logic [latency_width_p-1:0] latency_i,
  output logic                       ready_o,
  input  logic                       clear_i,
  input  logic                       rd_v_i,
  input  logic [1:0]                 rd_type_i,
  input  logic [4:0]                 rd_sel_i,
  output logic                       rd_v_o,
  output logic [sum_width_p-1:0]     rd_data_o,
  output logic                       overflow_o
);

  localparam int bin_w_lp = $clog2(num_bins_p);

  logic                       r_ready_en;
  logic                       r_stage_v;
  logic [1:0]                 r_stage_type;
  logic [latency_width_p-1:0] r_stage_lat;
  logic                       r_overflow;
  logic                       r_rd_v;
  logic [sum_width_p-1:0]     r_rd_data;

  logic                         w_accept;
  logic [bin_w_lp-1:0]          w_bin_idx;
  logic [rl_stat_num_types-1:0] w_sat;
  logic [sum_width_p-1:0]       w_type_rd [rl_stat_num_types];
  logic [sum_width_p-1:0]       w_rd_data;

  // clear_i blocks acceptance so the cycle's event is dropped with the stats
  assign ready_o    = r_ready_en & ~clear_i;
  assign w_accept   = v_i & ready_o;
  assign rd_v_o     = r_rd_v;
  assign rd_data_o  = r_rd_data;
  assign overflow_o = r_overflow;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ready_en   <= 1'b0;
      r_stage_v    <= 1'b0;
      r_stage_type <= 2'd0;
      r_stage_lat  <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_stage_v  <= w_accept;
      if (w_accept) begin
        r_stage_type <= type_i;
        r_stage_lat  <= latency_i;
      end
    end
  end

  rl_latency_bin_index #(
    .num_bins_p      (num_bins_p),
    .latency_width_p (latency_width_p),
    .bin_w_p         (bin_w_lp)
  ) u_bin_index (
    .i_latency (r_stage_lat),
    .o_bin     (w_bin_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < rl_stat_num_types; gi++) begin : g_type
      logic [count_width_p-1:0]   r_count;
      logic [sum_width_p-1:0]     r_sum;
      logic [latency_width_p-1:0] r_max;
      logic [latency_width_p-1:0] r_min;
      logic [count_width_p-1:0]   r_bins [num_bins_p];

      logic                     w_hit;
      logic [count_width_p:0]   w_cnt_add;
      logic [sum_width_p:0]     w_sum_add;
      logic [count_width_p:0]   w_bin_add;
      logic [count_width_p-1:0] w_cnt_next;
      logic [sum_width_p-1:0]   w_sum_next;
      logic [count_width_p-1:0] w_bin_next;
      rl_stat_s                 w_fields;
      logic [sum_width_p-1:0]   w_rd;

      assign w_hit = r_stage_v & (r_stage_type == 2'(gi));

      // carry out of each adder clamps the result to all-ones
      assign w_cnt_add  = {1'b0, r_count} + {{count_width_p{1'b0}}, 1'b1};
      assign w_sum_add  = {1'b0, r_sum} + (sum_width_p + 1)'(r_stage_lat);
      assign w_bin_add  = {1'b0, r_bins[w_bin_idx]} + {{count_width_p{1'b0}}, 1'b1};
      assign w_cnt_next = w_cnt_add[count_width_p] ? '1 : w_cnt_add[count_width_p-1:0];
      assign w_sum_next = w_sum_add[sum_width_p] ? '1 : w_sum_add[sum_width_p-1:0];
      assign w_bin_next = w_bin_add[count_width_p] ? '1 : w_bin_add[count_width_p-1:0];

      assign w_sat[gi] = w_hit & ((&w_cnt_next) | (&w_sum_next) | (&w_bin_next));

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_count <= '0;
          r_sum   <= '0;
          r_max   <= '0;
          r_min   <= '1;
          for (int b = 0; b < num_bins_p; b++) r_bins[b] <= '0;
        end else if (clear_i) begin
          r_count <= '0;
          r_sum   <= '0;
          r_max   <= '0;
          r_min   <= '1;
          for (int b = 0; b < num_bins_p; b++) r_bins[b] <= '0;
        end else if (w_hit) begin
          r_count <= w_cnt_next;
          r_sum   <= w_sum_next;
          if (r_stage_lat > r_max) r_max <= r_stage_lat;
          if (r_stage_lat < r_min) r_min <= r_stage_lat;
          r_bins[w_bin_idx] <= w_bin_next;
        end
      end

      always_comb begin
        w_fields = '{
          count:   rl_stat_field_w'(r_count),
          sum:     rl_stat_field_w'(r_sum),
          lat_max: rl_stat_field_w'(r_max),
          lat_min: rl_stat_field_w'(r_min)
        };
        w_rd = '0;
        case (rd_sel_i)
          rl_sel_count: w_rd = sum_width_p'(w_fields.count);
          rl_sel_sum:   w_rd = sum_width_p'(w_fields.sum);
          rl_sel_max:   w_rd = sum_width_p'(w_fields.lat_max);
          rl_sel_min:   w_rd = sum_width_p'(w_fields.lat_min);
          default: begin
            // selects past the last bin fall through and read as zero
            for (int k = 0; k < num_bins_p; k++) begin
              if (rd_sel_i == 5'(int'(rl_sel_bin0) + k)) w_rd = sum_width_p'(r_bins[k]);
            end
          end
        endcase
      end

      assign w_type_rd[gi] = w_rd;
    end
  endgenerate

  always_comb begin
    w_rd_data = '0;
    case (rl_stat_type_e'(rd_type_i))
      e_rl_stat_int:    w_rd_data = w_type_rd[0];
      e_rl_stat_float:  w_rd_data = w_type_rd[1];
      e_rl_stat_icache: w_rd_data = w_type_rd[2];
      default:          w_rd_data = '0;
    endcase
  end

  // the query samples the stats before this edge's update or clear lands
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_v <= rd_v_i;
      if (rd_v_i) r_rd_data <= w_rd_data;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
    end else if (|w_sat) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/remote_load_latency_stats.md
REMOTE_LOAD_LATENCY_STATS -- requirements
Module: remote_load_latency_stats

Interface
REQ-001 SHALL have parameter num_bins_p, default 8: number of log2 latency histogram bins per type (2..16).
REQ-002 SHALL have parameter latency_width_p, default 32: width of the incoming latency.
REQ-003 SHALL have parameter count_width_p, default 32: width of the count and bin counters.
REQ-004 SHALL have parameter sum_width_p, default 48: width of the latency accumulator.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port v_i, input, 1 bit: completion event valid.
REQ-008 SHALL have port type_i, input, 2 bits: event type (int / float / icache / reserved).
REQ-009 SHALL have port latency_i, input, latency_width_p bits: end_cycle minus start_cycle.
REQ-010 SHALL have port ready_o, output, 1 bit: event accepted when v_i & ready_o.
REQ-011 SHALL have port clear_i, input, 1 bit: synchronous zeroing of all statistics.
REQ-012 SHALL have port rd_v_i, input, 1 bit: query request.
REQ-013 SHALL have port rd_type_i, input, 2 bits: type being queried.
REQ-014 SHALL have port rd_sel_i, input, 5 bits: field select (0 count, 1 sum, 2 max, 3 min, 4+k bin k).
REQ-015 SHALL have port rd_v_o, output, 1 bit: query data valid.
REQ-016 SHALL have port rd_data_o, output, sum_width_p bits: queried value, zero-extended.
REQ-017 SHALL have port overflow_o, output, 1 bit: sticky flag, set when any counter or sum saturates.

Function
REQ-018 SHALL register each accepted event in a one-entry stage register (cycle N); statistics update at the edge ending cycle N+1, giving an update latency of 2 edges.
REQ-019 SHALL drive ready_o = 1 except during a cycle with clear_i = 1 or while reset is asserted, so back-to-back events are sustained at 1 per cycle.
REQ-020 SHALL update the following per type 0..2 on each staged event: count+1; sum+latency; max=max(max,latency); min=min(min,latency); the selected bin +1.
REQ-021 SHALL select bin 0 for latency < 2, bin k for 2^k <= latency < 2^(k+1), and bin num_bins_p-1 for any latency >= 2^(num_bins_p-1).
REQ-022 SHALL accept type 3 events and modify no statistic with them.
REQ-023 SHALL hold count, bin, and sum values at their maximum once they reach it (saturating counters, no wrap) and set overflow_o.
REQ-024 SHALL hold min at all-ones after reset or clear until the first event of that type arrives.
REQ-025 SHALL answer a query with rd_v_o = 1 and rd_data_o one cycle after rd_v_i.
REQ-026 SHALL return 0 for rd_sel_i beyond 4+num_bins_p-1, and 0 for rd_type_i = 3.
REQ-027 SHALL return the pre-update value when a query and an update to the same statistic occur on the same edge.
REQ-028 SHALL, on clear_i = 1, zero all statistics and overflow_o at the next edge, set min to all-ones, and discard the staged event.
REQ-029 SHALL give clear_i priority over an update on the same edge; a query issued in the clear cycle returns the pre-clear value.

Reset
REQ-030 SHALL, while reset_n_i is low (asynchronously), set all counters, sums, max and bins to 0, min to all-ones, and the stage valid, rd_v_o, rd_data_o, and overflow_o to 0.
REQ-031 SHALL hold ready_o at 0 while reset_n_i is low and raise it at the first edge after deassertion.
REQ-032 SHALL discard any event in flight when reset is asserted mid-operation; no partial update is permitted.

Structure
REQ-033 SHALL define the following in a shared trace-statistics package: the type enum (e_rl_stat_int = 0, e_rl_stat_float = 1, e_rl_stat_icache = 2, e_rl_stat_rsvd = 3), the rd_sel_i field encodings, and the per-type statistics struct.
REQ-034 SHALL implement the log2 bin-index computation as one sub-module, rl_latency_bin_index (a priority encoder with clamp).

Verification
REQ-035 SHALL cover: reset, then int events with latencies 5, 1, 300 -> int count = 3, sum = 306, max = 300, min = 1, bin0 = 1, bin2 = 1, bin7 = 1.
REQ-036 SHALL cover: float event latency 2 and, the next cycle, a query on float count -> query returns 0; a repeat query 2 cycles later returns 1.
REQ-037 SHALL cover: a sum preloaded (by forcing) to 2^48 minus 10, then an icache event latency 20 -> sum = 2^48 minus 1 and overflow_o = 1.
REQ-038 SHALL cover: clear_i asserted in the same cycle as an accepted int event latency 7 -> ready_o = 0 that cycle, all int statistics = 0, and min = all-ones.
REQ-039 SHALL cover: reset_n_i pulsed low mid-stream between events -> outputs go to their reset values immediately and no statistic reflects the staged event.
REQ-040 SHALL cover: a type 3 event followed by 8 back-to-back int events with latency 1 -> int count = 8, bin0 = 8, and type 3 queries return 0.
